bldc_commutator: RTL and testbench
==================================

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 Parameter DEADTIME_CYCLES, default 1024, number of cycles all gates are held low on every commutation change; legal range 1..65535.
REQ-002 clk  in  1  system clock, 16 MHz; all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 enable  in  1  drive permission; 0 forces all gates low.
REQ-005 dir  in  1  rotation direction; 1 selects the forward table, 0 the reverse table.
REQ-006 hall  in  3  debounced hall inputs {h1,h2,h3}, synchronous to clk.
REQ-007 pwm_in  in  1  PWM from the pwm stage, gated onto the high sides.
REQ-008 fault_n  in  1  gate-driver fault, active-low, synchronous to clk.
REQ-009 clear_fault  in  1  level; releases a latched fault.
REQ-010 inha, inla, inhb, inlb, inhc, inlc  out  1 each  registered gate drives.
REQ-011 comm_state  out  3  current sector: A=0, B=1, C=2, D=3, E=4, F=5.
REQ-012 step  out  1  one-cycle pulse on each valid sector change.
REQ-013 hall_error  out  1  sticky flag; set on an invalid hall code (000 or 111).
REQ-014 fault_latched  out  1  high while the block is in FAULT.

Function
REQ-015 hall SHALL be registered once into hall_q; each sector decode uses hall_q.
- Decode (h1h2h3): 101=A, 100=B, 110=C, 010=D, 011=E, 001=F.
REQ-016 comm_state SHALL update on the cycle after hall_q takes a valid code; an invalid code leaves it unchanged.
- step pulses on that same cycle, only if the new value differs from the old one.
REQ-017 FSM states SHALL be OFF, DEADTIME, DRIVE and FAULT, with priority reset > fault > enable=0 > invalid hall > sector/dir change > counter expiry.
REQ-018 OFF: all gates 0.
- Goes to DEADTIME when enable=1, fault_n=1 and hall_q is valid.
REQ-019 DEADTIME: all gates 0 for exactly DEADTIME_CYCLES cycles, then DRIVE.
- Any sector change or dir change during DEADTIME reloads the count.
REQ-020 DRIVE: the low side is a static 1; the high side is the selected high enable AND pwm_in, registered, so pwm_in reaches the pin with 1-cycle latency.
REQ-021 Forward table (dir=1), high/low leg per sector: A=C/B, B=A/B, C=A/C, D=B/C, E=B/A, F=C/A.
REQ-022 Reverse table (dir=0), high/low leg per sector: A=B/C, B=B/A, C=C/A, D=C/B, E=A/B, F=A/C.
REQ-023 In DRIVE, a sector change or dir change SHALL go to DEADTIME, with all gates 0 on the next edge.
- Worst case is hall pin change at edge t, gates 0 by edge t+3.
REQ-024 In DRIVE, enable=0 SHALL go to OFF.
- An invalid hall_q goes to OFF and sets hall_error.
REQ-025 fault_n=0 in any state SHALL go to FAULT on the next edge, with gates 0 and fault_latched=1.
REQ-026 FAULT SHALL exit to OFF only when clear_fault=1 and fault_n=1 in the same cycle.
- clear_fault together with fault_n=0 keeps the block in FAULT.
REQ-027 The high and low sides of one leg SHALL never be 1 in the same cycle.
- Gate drives are never taken from combinational logic.

Reset
REQ-028 On reset=1 the block SHALL enter OFF with all six gates 0, comm_state=0, step=0, hall_error=0, fault_latched=0, the dead-time counter at 0 and hall_q=000.
- This holds in every state, including mid-DEADTIME and FAULT.
REQ-029 After reset is released, the block SHALL pass through a full DEADTIME before any gate asserts.

Verification
REQ-030 With DEADTIME_CYCLES=4, enable=1, dir=1, hall=100 and pwm_in=1, a bench SHALL check that inha=1 and inlb=1 first appear 1 (hall_q) + 1 (decode) + 4 (dead time) cycles after reset release, with the other gates 0.
REQ-031 A bench SHALL check that moving hall 100->110 in DRIVE gives all gates 0 for 4 cycles, then inha=1 and inlc=1, with step high for exactly one cycle.
REQ-032 A bench SHALL check that toggling dir in DRIVE on sector C gives 4 dead cycles, then inhc=1 and inla=1.
REQ-033 A bench SHALL check that hall=111 in DRIVE sets hall_error=1 and zeroes the gates, and that a return to 101 gives DEADTIME then inhc=1 and inlb=1 while hall_error stays 1.
REQ-034 A bench SHALL check that fault_n=0 for 1 cycle latches FAULT with gates 0, that clear_fault with fault_n=0 is ignored, and that clear_fault with fault_n=1 gives OFF, then DEADTIME, then DRIVE.
REQ-035 A bench SHALL check that a 50% pwm_in in DRIVE sector E (dir=1) makes inhb follow pwm_in delayed 1 cycle, with inla=1 constant and no leg ever having high and low both 1.

Source files
------------

// File: rtl/bldc_commutator.sv
// BLDC six-step commutator.
// Hall inputs are registered once, decoded into a sector, and used to select
// one high-side leg and one low-side leg. A four-state FSM
// (OFF / DEADTIME / DRIVE / FAULT) guarantees every sector or direction change
// passes through a full dead-time window with all gates low. All six gate
// drives come straight from flops.

module bldc_commutator #(
  parameter int unsigned DEADTIME_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic       pwm_in,
  input  logic       fault_n,
  input  logic       clear_fault,
  output logic       inha,
  output logic       inla,
  output logic       inhb,
  output logic       inlb,
  output logic       inhc,
  output logic       inlc,
  output logic [2:0] comm_state,
  output logic       step,
  output logic       hall_error,
  output logic       fault_latched
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // Leg encoding; LEG_NONE selects nothing so an unknown sector drives no gate.
  localparam logic [1:0] LEG_A    = 2'd0;
  localparam logic [1:0] LEG_B    = 2'd1;
  localparam logic [1:0] LEG_C    = 2'd2;
  localparam logic [1:0] LEG_NONE = 2'd3;

  // The counter runs from DEADTIME_CYCLES-1 down to 0, giving exactly
  // DEADTIME_CYCLES cycles in DEADTIME before DRIVE is entered.
  localparam logic [15:0] DT_LOAD = 16'(DEADTIME_CYCLES - 1);

  // Hall code to {valid, sector}; 000 and 111 are invalid.
  function automatic logic [3:0] decode_hall(input logic [2:0] h);
    logic [3:0] r;
    case (h)
      3'b101:  r = {1'b1, 3'd0};
      3'b100:  r = {1'b1, 3'd1};
      3'b110:  r = {1'b1, 3'd2};
      3'b010:  r = {1'b1, 3'd3};
      3'b011:  r = {1'b1, 3'd4};
      3'b001:  r = {1'b1, 3'd5};
      default: r = {1'b0, 3'd0};
    endcase
    return r;
  endfunction

  // Sector and direction to {high leg, low leg}.
  function automatic logic [3:0] leg_select(input logic [2:0] sector, input logic fwd);
    logic [3:0] r;
    if (fwd) begin
      case (sector)
        3'd0:    r = {LEG_C, LEG_B};
        3'd1:    r = {LEG_A, LEG_B};
        3'd2:    r = {LEG_A, LEG_C};
        3'd3:    r = {LEG_B, LEG_C};
        3'd4:    r = {LEG_B, LEG_A};
        3'd5:    r = {LEG_C, LEG_A};
        default: r = {LEG_NONE, LEG_NONE};
      endcase
    end else begin
      case (sector)
        3'd0:    r = {LEG_B, LEG_C};
        3'd1:    r = {LEG_B, LEG_A};
        3'd2:    r = {LEG_C, LEG_A};
        3'd3:    r = {LEG_C, LEG_B};
        3'd4:    r = {LEG_A, LEG_B};
        3'd5:    r = {LEG_A, LEG_C};
        default: r = {LEG_NONE, LEG_NONE};
      endcase
    end
    return r;
  endfunction

  logic [2:0]  hall_q_r;
  logic        dir_q_r;
  logic [2:0]  comm_state_r;
  logic        step_r;
  logic        hall_error_r;
  logic        fault_latched_r;
  state_t      state_r;
  logic [15:0] cnt_r;
  logic [5:0]  gates_r;   // {inha, inla, inhb, inlb, inhc, inlc}

  logic [3:0]  dec_s;
  logic        hall_valid_s;
  logic [2:0]  hall_sector_s;
  logic        sector_change_s;
  logic        dir_change_s;
  logic        change_s;
  state_t      state_nx_s;
  logic [15:0] cnt_nx_s;
  logic        hall_err_set_s;
  logic [3:0]  legs_s;
  logic [1:0]  hi_leg_s;
  logic [1:0]  lo_leg_s;
  logic [5:0]  gates_nx_s;

  // Decode the registered hall code and flag sector or direction changes.
  always_comb begin
    dec_s           = decode_hall(hall_q_r);
    hall_valid_s    = dec_s[3];
    hall_sector_s   = dec_s[2:0];
    sector_change_s = hall_valid_s && (hall_sector_s != comm_state_r);
    dir_change_s    = (dir != dir_q_r);
    change_s        = sector_change_s || dir_change_s;
  end

  // Input capture, sector tracking, step pulse and sticky hall error.
  always_ff @(posedge clk) begin
    if (reset) begin
      hall_q_r     <= 3'b000;
      dir_q_r      <= 1'b0;
      comm_state_r <= 3'd0;
      step_r       <= 1'b0;
      hall_error_r <= 1'b0;
    end else begin
      hall_q_r <= hall;
      dir_q_r  <= dir;
      if (hall_valid_s) begin
        comm_state_r <= hall_sector_s;
        step_r       <= sector_change_s;
      end else begin
        step_r       <= 1'b0;
      end
      if (hall_err_set_s) begin
        hall_error_r <= 1'b1;
      end else begin
        hall_error_r <= hall_error_r;
      end
    end
  end

  // Next-state and dead-time counter; checks are ordered by priority.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    hall_err_set_s = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (!fault_n) begin
          state_nx_s = ST_FAULT;
          cnt_nx_s   = 16'd0;
        end else if (enable && hall_valid_s) begin
          state_nx_s = ST_DEADTIME;
          cnt_nx_s   = DT_LOAD;
        end else begin
          state_nx_s = ST_OFF;
        end
      end
      ST_DEADTIME: begin
        if (!fault_n) begin
          state_nx_s = ST_FAULT;
          cnt_nx_s   = 16'd0;
        end else if (!enable) begin
          state_nx_s = ST_OFF;
          cnt_nx_s   = 16'd0;
        end else if (!hall_valid_s) begin
          state_nx_s     = ST_OFF;
          cnt_nx_s       = 16'd0;
          hall_err_set_s = 1'b1;
        end else if (change_s) begin
          cnt_nx_s = DT_LOAD;
        end else if (cnt_r == 16'd0) begin
          state_nx_s = ST_DRIVE;
        end else begin
          cnt_nx_s = cnt_r - 16'd1;
        end
      end
      ST_DRIVE: begin
        if (!fault_n) begin
          state_nx_s = ST_FAULT;
          cnt_nx_s   = 16'd0;
        end else if (!enable) begin
          state_nx_s = ST_OFF;
          cnt_nx_s   = 16'd0;
        end else if (!hall_valid_s) begin
          state_nx_s     = ST_OFF;
          cnt_nx_s       = 16'd0;
          hall_err_set_s = 1'b1;
        end else if (change_s) begin
          state_nx_s = ST_DEADTIME;
          cnt_nx_s   = DT_LOAD;
        end else begin
          state_nx_s = ST_DRIVE;
        end
      end
      ST_FAULT: begin
        if (clear_fault && fault_n) begin
          state_nx_s = ST_OFF;
        end else begin
          state_nx_s = ST_FAULT;
        end
        cnt_nx_s = 16'd0;
      end
      default: begin
        state_nx_s = ST_OFF;
        cnt_nx_s   = 16'd0;
      end
    endcase
  end

  // Next gate pattern: only in DRIVE, high sides gated by pwm_in, and a
  // per-leg interlock so high and low of one leg can never both be set.
  always_comb begin
    legs_s     = leg_select(comm_state_r, dir);
    hi_leg_s   = legs_s[3:2];
    lo_leg_s   = legs_s[1:0];
    gates_nx_s = 6'b000000;
    if (state_nx_s == ST_DRIVE) begin
      gates_nx_s[4] = (lo_leg_s == LEG_A);
      gates_nx_s[2] = (lo_leg_s == LEG_B);
      gates_nx_s[0] = (lo_leg_s == LEG_C);
      gates_nx_s[5] = (hi_leg_s == LEG_A) && pwm_in && !gates_nx_s[4];
      gates_nx_s[3] = (hi_leg_s == LEG_B) && pwm_in && !gates_nx_s[2];
      gates_nx_s[1] = (hi_leg_s == LEG_C) && pwm_in && !gates_nx_s[0];
    end else begin
      gates_nx_s = 6'b000000;
    end
  end

  // FSM state, counter, fault flag and gate drive registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_OFF;
      cnt_r           <= 16'd0;
      fault_latched_r <= 1'b0;
      gates_r         <= 6'b000000;
    end else begin
      state_r         <= state_nx_s;
      cnt_r           <= cnt_nx_s;
      fault_latched_r <= (state_nx_s == ST_FAULT);
      gates_r         <= gates_nx_s;
    end
  end

  assign inha          = gates_r[5];
  assign inla          = gates_r[4];
  assign inhb          = gates_r[3];
  assign inlb          = gates_r[2];
  assign inhc          = gates_r[1];
  assign inlc          = gates_r[0];
  assign comm_state    = comm_state_r;
  assign step          = step_r;
  assign hall_error    = hall_error_r;
  assign fault_latched = fault_latched_r;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator with a 4-cycle dead time.
// Inputs change 2 ns after each rising edge; outputs are sampled at the same
// point, so each check reflects the edge just taken.

module tb_bldc_commutator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       dir;
  logic [2:0] hall;
  logic       pwm_in;
  logic       fault_n;
  logic       clear_fault;
  logic       inha, inla, inhb, inlb, inhc, inlc;
  logic [2:0] comm_state;
  logic       step;
  logic       hall_error;
  logic       fault_latched;

  logic [5:0] gates;
  assign gates = {inha, inla, inhb, inlb, inhc, inlc};

  int n_cmp;
  int n_bad;

  localparam logic [5:0] G_OFF = 6'b000000;
  localparam logic [5:0] G_AB  = 6'b100100;  // inha, inlb
  localparam logic [5:0] G_AC  = 6'b100001;  // inha, inlc
  localparam logic [5:0] G_CA  = 6'b010010;  // inhc, inla
  localparam logic [5:0] G_CB  = 6'b000110;  // inhc, inlb
  localparam logic [5:0] G_BA  = 6'b011000;  // inhb, inla
  localparam logic [5:0] G_A_L = 6'b010000;  // inla only (pwm low)

  bldc_commutator #(.DEADTIME_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .dir           (dir),
    .hall          (hall),
    .pwm_in        (pwm_in),
    .fault_n       (fault_n),
    .clear_fault   (clear_fault),
    .inha          (inha),
    .inla          (inla),
    .inhb          (inhb),
    .inlb          (inlb),
    .inhc          (inhc),
    .inlc          (inlc),
    .comm_state    (comm_state),
    .step          (step),
    .hall_error    (hall_error),
    .fault_latched (fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and confirm no leg has both sides on.
  task automatic cyc();
    @(posedge clk);
    #2;
    chk("no_shoot_through", {5'd0, inha & inla, inhb & inlb, inhc & inlc}, 8'd0);
  endtask

  task automatic chk_g(input string tag, input logic [5:0] exp);
    chk(tag, {2'b00, gates}, {2'b00, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; enable = 1'b1; dir = 1'b1; hall = 3'b100;
    pwm_in = 1'b1; fault_n = 1'b1; clear_fault = 1'b0;

    // Reset state
    cyc(); cyc();
    chk_g("reset_gates", G_OFF);
    chk("reset_comm_state", {5'd0, comm_state}, 8'd0);
    chk("reset_step", {7'd0, step}, 8'd0);
    chk("reset_hall_error", {7'd0, hall_error}, 8'd0);
    chk("reset_fault", {7'd0, fault_latched}, 8'd0);

    // Startup: 1 hall_q + 1 decode + 4 dead cycles, then sector B forward
    reset = 1'b0;
    cyc(); chk_g("start_e1", G_OFF);
    chk("start_comm_e1", {5'd0, comm_state}, 8'd0);
    cyc(); chk_g("start_e2", G_OFF);
    chk("start_comm_e2", {5'd0, comm_state}, 8'd1);
    chk("start_step_e2", {7'd0, step}, 8'd1);
    cyc(); chk_g("start_e3", G_OFF);
    chk("start_step_e3", {7'd0, step}, 8'd0);
    cyc(); chk_g("start_e4", G_OFF);
    cyc(); chk_g("start_e5", G_OFF);
    cyc(); chk_g("start_e6_drive", G_AB);
    cyc(); chk_g("start_hold", G_AB);

    // Sector B -> C
    hall = 3'b110;
    cyc(); chk_g("bc_latency", G_AB);
    cyc(); chk_g("bc_dead1", G_OFF);
    chk("bc_step_hi", {7'd0, step}, 8'd1);
    chk("bc_comm", {5'd0, comm_state}, 8'd2);
    cyc(); chk_g("bc_dead2", G_OFF);
    chk("bc_step_lo", {7'd0, step}, 8'd0);
    cyc(); chk_g("bc_dead3", G_OFF);
    cyc(); chk_g("bc_dead4", G_OFF);
    cyc(); chk_g("bc_drive", G_AC);

    // Direction toggle on sector C
    dir = 1'b0;
    cyc(); chk_g("dir_dead1", G_OFF);
    cyc(); chk_g("dir_dead2", G_OFF);
    cyc(); chk_g("dir_dead3", G_OFF);
    cyc(); chk_g("dir_dead4", G_OFF);
    chk("dir_no_step", {7'd0, step}, 8'd0);
    cyc(); chk_g("dir_drive_rev_c", G_CA);

    // Back to forward, then invalid hall 111
    dir = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    cyc(); chk_g("fwd_c_again", G_AC);
    hall = 3'b111;
    cyc(); chk_g("inv_latency", G_AC);
    cyc(); chk_g("inv_off", G_OFF);
    chk("inv_hall_error", {7'd0, hall_error}, 8'd1);
    chk("inv_comm_kept", {5'd0, comm_state}, 8'd2);
    cyc(); chk_g("inv_stay_off", G_OFF);
    hall = 3'b101;
    cyc(); chk_g("rec_e1", G_OFF);
    cyc(); chk_g("rec_e2", G_OFF);
    chk("rec_comm", {5'd0, comm_state}, 8'd0);
    cyc(); cyc(); cyc();
    chk_g("rec_e5", G_OFF);
    cyc(); chk_g("rec_drive_a", G_CB);
    chk("rec_err_sticky", {7'd0, hall_error}, 8'd1);

    // Fault latch and release
    fault_n = 1'b0;
    cyc(); chk_g("flt_gates", G_OFF);
    chk("flt_latched", {7'd0, fault_latched}, 8'd1);
    fault_n = 1'b1;
    cyc(); cyc();
    chk("flt_held", {7'd0, fault_latched}, 8'd1);
    chk_g("flt_held_gates", G_OFF);
    clear_fault = 1'b1; fault_n = 1'b0;
    cyc();
    chk("flt_clear_ignored", {7'd0, fault_latched}, 8'd1);
    fault_n = 1'b1;
    cyc();
    chk("flt_cleared", {7'd0, fault_latched}, 8'd0);
    chk_g("flt_off_gates", G_OFF);
    clear_fault = 1'b0;
    cyc(); chk_g("flt_dead1", G_OFF);
    cyc(); cyc(); cyc();
    chk_g("flt_dead4", G_OFF);
    cyc(); chk_g("flt_drive", G_CB);

    // Sector E forward with 50% PWM
    hall = 3'b011;
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    chk_g("e_drive", G_BA);
    chk("e_comm", {5'd0, comm_state}, 8'd4);
    for (int i = 0; i < 8; i++) begin
      pwm_in = ((i % 4) < 2) ? 1'b0 : 1'b1;
      cyc();
      chk_g("pwm_follow", pwm_in ? G_BA : G_A_L);
    end
    pwm_in = 1'b1;

    // enable=0 goes to OFF
    enable = 1'b0;
    cyc(); chk_g("disable_off", G_OFF);

    // Reset in the middle of DEADTIME
    enable = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk_g("midreset_gates", G_OFF);
    chk("midreset_err", {7'd0, hall_error}, 8'd0);
    chk("midreset_comm", {5'd0, comm_state}, 8'd0);
    chk("midreset_fault", {7'd0, fault_latched}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
